// File: rtl/s2_sel_seq.sv
// Select sequencer for the s2 registered logic cell: steps s2 through D0..D3 in a programmed
// order for a programmed number of passes and tags each fresh s2 output word with its channel.
module s2_sel_seq #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [1:0]       chan,
  input  logic [CNT_W-1:0] reps,
  output logic             A1,
  output logic             B1,
  output logic             A0,
  output logic             B0,
  output logic             busy,
  output logic             out_valid,
  output logic [1:0]       valid_sel,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [1:0]       chan_q;
  logic [CNT_W-1:0] reps_q;
  logic [CNT_W-1:0] pass_q;
  logic [2:0]       step_q;

  logic [2:0] len_m1;
  logic       last_step;
  logic       last_pass;
  logic [1:0] cur_ch;
  logic [1:0] next_ch;
  logic [1:0] first_ch;

  function automatic logic [2:0] seq_len(input logic [1:0] m);
    logic [2:0] len;
    case (m)
      2'd2:    len = 3'd1;
      2'd3:    len = 3'd6;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

  function automatic logic [1:0] step_chan(input logic [1:0] m, input logic [2:0] s,
                                           input logic [1:0] c);
    logic [1:0] ch;
    logic [2:0] back;
    back = 3'd6 - s;
    case (m)
      2'd0:    ch = s[1:0];
      2'd1:    ch = 2'd3 - s[1:0];
      2'd2:    ch = c;
      default: ch = (s < 3'd4) ? s[1:0] : back[1:0]; // ping-pong: 0,1,2,3 then 2,1
    endcase
    return ch;
  endfunction

  always_comb begin
    len_m1    = seq_len(mode_q) - 3'd1;
    last_step = (step_q == len_m1);
    last_pass = (pass_q == reps_q - CNT_W'(1));
    cur_ch    = step_chan(mode_q, step_q, chan_q);
    next_ch   = step_chan(mode_q, last_step ? 3'd0 : step_q + 3'd1, chan_q);
    first_ch  = step_chan(mode, 3'd0, chan);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      chan_q    <= 2'd0;
      reps_q    <= '0;
      pass_q    <= '0;
      step_q    <= 3'd0;
      A1        <= 1'b0;
      B1        <= 1'b0;
      A0        <= 1'b0;
      B0        <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      valid_sel <= 2'd0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done      <= 1'b0;
          out_valid <= 1'b0;
          if (start) begin
            mode_q <= mode;
            chan_q <= chan;
            reps_q <= reps;
            pass_q <= '0;
            step_q <= 3'd0;
            if (reps == '0) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              A1      <= first_ch[1];
              B1      <= 1'b0;
              A0      <= first_ch[0];
              B0      <= first_ch[0];
            end
          end
        end
        StRun: begin
          // s2 captures this cycle's select at the edge, so tag it for the next cycle
          out_valid <= 1'b1;
          valid_sel <= cur_ch;
          if (last_step && last_pass) begin
            state_q <= StDrain;
            A1      <= 1'b0;
            B1      <= 1'b0;
            A0      <= 1'b0;
            B0      <= 1'b0;
          end else begin
            if (last_step) begin
              step_q <= 3'd0;
              pass_q <= pass_q + CNT_W'(1);
            end else begin
              step_q <= step_q + 3'd1;
            end
            A1 <= next_ch[1];
            B1 <= 1'b0;
            A0 <= next_ch[0];
            B0 <= next_ch[0];
          end
        end
        StDrain: begin
          state_q   <= StDone;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
